// File: rtl/dut_tester_pkg.sv
// Shared definitions for the tester drive and response blocks:
// pin/counter widths, sequencer state encoding and cycle-length decoding.
package dut_tester_pkg;

    localparam int unsigned NPINS = 128;
    localparam int unsigned CNTW  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } tester_state_e;

    // A programmed length of 0 encodes the full 256-tick cycle.
    function automatic logic [8:0] eff_len(input logic [7:0] cycle_length);
        return (cycle_length == 8'd0) ? 9'd256 : {1'b0, cycle_length};
    endfunction

endpackage

// File: rtl/dut_resp_cmp_exp_dbuf.sv
// Shadow/active expect+mask double buffer. A transfer requested while the
// sequencer is busy is held pending and applied on the next tick wrap.
module exp_dbuf #(
    parameter int unsigned NPINS = dut_tester_pkg::NPINS
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             transfer_i,
    input  logic             busy_i,
    input  logic             wrap_i,
    input  logic [NPINS-1:0] exp_i,
    input  logic [NPINS-1:0] mask_i,
    output logic [NPINS-1:0] exp_o,
    output logic [NPINS-1:0] mask_o
);

    logic [NPINS-1:0] sh_exp_q, sh_mask_q;
    logic [NPINS-1:0] act_exp_q, act_mask_q;
    logic             pend_q, pend_d;
    logic             req, copy;

    always_comb begin
        req    = transfer_i | pend_q;
        copy   = req & (~busy_i | wrap_i);
        pend_d = req & ~copy;
    end

    // Copy reads the pre-edge shadow, so a same-edge load lands after it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sh_exp_q   <= '0;
            sh_mask_q  <= '0;
            act_exp_q  <= '0;
            act_mask_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            if (load_i) begin
                sh_exp_q  <= exp_i;
                sh_mask_q <= mask_i;
            end
            if (copy) begin
                act_exp_q  <= sh_exp_q;
                act_mask_q <= sh_mask_q;
            end
            pend_q <= pend_d;
        end
    end

    assign exp_o  = act_exp_q;
    assign mask_o = act_mask_q;

endmodule

// File: rtl/dut_resp_cmp.sv
// Response comparator: strobes the DUT pins once per tester cycle, checks them
// against the masked active expect and records fail count and first failure.
module dut_resp_cmp #(
    parameter int unsigned NPINS = dut_tester_pkg::NPINS,
    parameter int unsigned CNTW  = dut_tester_pkg::CNTW
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NPINS-1:0] DUT_SIGNALS,
    input  logic [NPINS-1:0] BUS128_0,
    input  logic [NPINS-1:0] BUS128_1,
    input  logic             EXP_LOAD,
    input  logic             EXP_TRANSFER,
    input  logic             START_TEST,
    input  logic [6:0]       STROBE_EDGE,
    input  logic [7:0]       CYCLE_LENGTH,
    input  logic [CNTW-1:0]  NUM_VECTORS,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic             STROBE_ERR,
    output logic [CNTW-1:0]  FAIL_COUNT,
    output logic [CNTW-1:0]  FIRST_FAIL_CYCLE,
    output logic [NPINS-1:0] FIRST_FAIL_VEC,
    output logic [NPINS-1:0] CAPTURED
);
    import dut_tester_pkg::*;

    tester_state_e    state_q, state_d;
    logic [7:0]       tick_q;
    logic [CNTW-1:0]  vec_q, nvec_q, cap_vec_q, fail_q, ffc_q;
    logic [6:0]       strobe_q;
    logic [8:0]       len_q;
    logic             err_q, cmp_q;
    logic [NPINS-1:0] cap_q, miss_q, ffv_q;
    logic [NPINS-1:0] exp_act, mask_act;
    logic             start_acc, busy, wrap, last_vec, strobe_hit;

    assign start_acc  = START_TEST && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign wrap       = (state_q == ST_RUN) && ({1'b0, tick_q} == (len_q - 9'd1));
    assign last_vec   = (vec_q == (nvec_q - CNTW'(1)));
    assign strobe_hit = (state_q == ST_RUN) && !err_q && (tick_q == {1'b0, strobe_q});

    exp_dbuf #(.NPINS(NPINS)) u_exp_dbuf (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .load_i     (EXP_LOAD),
        .transfer_i (EXP_TRANSFER),
        .busy_i     (busy),
        .wrap_i     (wrap),
        .exp_i      (BUS128_0),
        .mask_i     (BUS128_1),
        .exp_o      (exp_act),
        .mask_o     (mask_act)
    );

    always_ff @(posedge CLK) begin
        if (!RST) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START_TEST) state_d = (NUM_VECTORS == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN:   if (wrap && last_vec) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY = busy;
        DONE = (state_q == ST_DONE);
        PASS = (state_q == ST_DONE) && (fail_q == '0) && !err_q;
    end

    // The miss vector is formed against the expect active at the strobe so a
    // transfer landing on the same wrap edge cannot leak into the old cycle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            tick_q    <= '0;
            vec_q     <= '0;
            nvec_q    <= '0;
            strobe_q  <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
            cap_q     <= '0;
            miss_q    <= '0;
            cmp_q     <= 1'b0;
            cap_vec_q <= '0;
            fail_q    <= '0;
            ffc_q     <= '0;
            ffv_q     <= '0;
        end else if (start_acc) begin
            tick_q    <= '0;
            vec_q     <= '0;
            nvec_q    <= NUM_VECTORS;
            strobe_q  <= STROBE_EDGE;
            len_q     <= eff_len(CYCLE_LENGTH);
            err_q     <= ({2'b00, STROBE_EDGE} >= eff_len(CYCLE_LENGTH));
            cap_q     <= '0;
            miss_q    <= '0;
            cmp_q     <= 1'b0;
            cap_vec_q <= '0;
            fail_q    <= '0;
            ffc_q     <= '0;
            ffv_q     <= '0;
        end else begin
            if (state_q == ST_RUN) begin
                tick_q <= wrap ? '0 : tick_q + 8'd1;
                if (wrap) vec_q <= vec_q + CNTW'(1);
            end
            cmp_q <= strobe_hit;
            if (strobe_hit) begin
                cap_q     <= DUT_SIGNALS;
                miss_q    <= (DUT_SIGNALS ^ exp_act) & mask_act;
                cap_vec_q <= vec_q;
            end
            if (cmp_q && (miss_q != '0)) begin
                if (fail_q == '0) begin
                    ffc_q <= cap_vec_q;
                    ffv_q <= miss_q;
                end
                if (fail_q != '1) fail_q <= fail_q + CNTW'(1);
            end
        end
    end

    assign STROBE_ERR       = err_q;
    assign FAIL_COUNT       = fail_q;
    assign FIRST_FAIL_CYCLE = ffc_q;
    assign FIRST_FAIL_VEC   = ffv_q;
    assign CAPTURED         = cap_q;

endmodule
